game_fsm: RTL and testbench

Parametrised turn-based game controller for the Lab 4 game logic. It owns the registered game state: idle, move selection, move check and game over. It rotates the active player over `N_PLAYERS`, enforces a per-turn timeout, and reports the winner. It sits between the debounced button inputs and the board/display logic, which supplies `finish` and consumes `state`, `player` and the pulse outputs.

---
 rtl/game_fsm.sv | 182 ++++++++++++++++++
 tb/tb_game_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm.sv
// game_fsm: turn-based game controller.
//
// Holds the registered game state (IDLE, SELECT, CHECK, GAME_OVER), rotates
// the active player over N_PLAYERS, enforces a per-turn timeout and reports
// the winner.
//
// Optional feature macro: GAME_FSM_TIMEOUT_EN
//   defined   -> turn timer and timeout pulse are built
//   undefined -> no timer register; turn_timer and timeout read 0 and
//                SELECT waits indefinitely for a select rise
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   clock enable; all registers hold while low
//   start      in   start / restart request (rising edge)
//   select     in   active player confirms a move (rising edge)
//   finish     in   win condition from board logic, sampled in CHECK
//   state      out  IDLE=00, SELECT=01, CHECK=10, GAME_OVER=11
//   player     out  active player index
//   turn_timer out  enabled cycles remaining in the current turn
//   commit     out  one-cycle pulse when a move is accepted
//   timeout    out  one-cycle pulse when a turn expires
//   winner     out  winning player, valid while game_over=1
//   game_over  out  high in GAME_OVER
module game_fsm #(
  parameter int N_PLAYERS   = 2,
  parameter int TURN_CYCLES = 50_000_000,
  localparam int PW = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1,
  localparam int TW = $clog2(TURN_CYCLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          start,
  input  logic          select,
  input  logic          finish,
  output logic [1:0]    state,
  output logic [PW-1:0] player,
  output logic [TW-1:0] turn_timer,
  output logic          commit,
  output logic          timeout,
  output logic [PW-1:0] winner,
  output logic          game_over
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_SELECT    = 2'b01,
    S_CHECK     = 2'b10,
    S_GAME_OVER = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] player_q, player_d;
  logic [PW-1:0] winner_q, winner_d;
  logic          commit_q, commit_d;
  logic          timeout_q, timeout_d;
  logic          start_q, start_d;
  logic          select_q, select_d;
  logic [PW-1:0] player_adv;
  logic          start_rise;
  logic          select_rise;

`ifdef GAME_FSM_TIMEOUT_EN
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(TURN_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  // Wrap explicitly so the index never leaves 0..N_PLAYERS-1, even when
  // N_PLAYERS is not a power of two.
  assign player_adv  = (player_q == PW'(N_PLAYERS - 1)) ? '0 : player_q + PW'(1);
  assign start_rise  = start & ~start_q;
  assign select_rise = select & ~select_q;

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    winner_d  = winner_q;
    commit_d  = 1'b0;
    timeout_d = 1'b0;
    start_d   = start_q;
    select_d  = select_q;
`ifdef GAME_FSM_TIMEOUT_EN
    timer_d   = timer_q;
`endif
    if (enable) begin
      start_d  = start;
      select_d = select;
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_d  = S_SELECT;
            player_d = '0;
`ifdef GAME_FSM_TIMEOUT_EN
            timer_d  = TIMER_RELOAD;
`endif
          end
        end
        S_SELECT: begin
          // A select rise on the expiry cycle takes priority over the timeout.
          if (select_rise) begin
            state_d  = S_CHECK;
            commit_d = 1'b1;
          end
`ifdef GAME_FSM_TIMEOUT_EN
          else if (timer_q == '0) begin
            timeout_d = 1'b1;
            player_d  = player_adv;
            timer_d   = TIMER_RELOAD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
`endif
        end
        S_CHECK: begin
          if (finish) begin
            state_d  = S_GAME_OVER;
            winner_d = player_q;
          end else begin
            state_d  = S_SELECT;
            player_d = player_adv;
`ifdef GAME_FSM_TIMEOUT_EN
            timer_d  = TIMER_RELOAD;
`endif
          end
        end
        S_GAME_OVER: begin
          if (start_rise) begin
            state_d  = S_IDLE;
            winner_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pulse registers load every clock so they fall back to 0 on disabled
  // cycles; all other state only changes through the enabled path above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      player_q  <= '0;
      winner_q  <= '0;
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      select_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      winner_q  <= winner_d;
      commit_q  <= commit_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      select_q  <= select_d;
    end
  end

`ifdef GAME_FSM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
  assign turn_timer = timer_q;
  assign timeout    = timeout_q;
`else
  assign turn_timer = '0;
  assign timeout    = 1'b0;
`endif

  assign state     = state_q;
  assign player    = player_q;
  assign winner    = winner_q;
  assign commit    = commit_q;
  assign game_over = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: self-checking bench for game_fsm with N_PLAYERS=3,
// TURN_CYCLES=4. A table of hand-derived vectors is applied first, then
// directed sequences for timeout, collision, enable and held buttons, then
// random stimulus compared against a behavioural game model, and finally
// asynchronous reset checks.
module tb_game_fsm;

  localparam int N  = 3;
  localparam int TC = 4;

`ifdef GAME_FSM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       select = 1'b0;
  logic       finish = 1'b0;
  logic [1:0] state;
  logic [1:0] player;
  logic [1:0] turn_timer;
  logic       commit;
  logic       timeout;
  logic [1:0] winner;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;

  game_fsm #(.N_PLAYERS(N), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .select(select), .finish(finish), .state(state), .player(player),
    .turn_timer(turn_timer), .commit(commit), .timeout(timeout),
    .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Behavioural game model: phase 0 idle, 1 selecting, 2 checking, 3 over.
  int m_phase, m_player, m_timer, m_winner;
  bit m_commit, m_timeout, m_prev_start, m_prev_select;

  task automatic modelReset();
    m_phase = 0; m_player = 0; m_timer = 0; m_winner = 0;
    m_commit = 0; m_timeout = 0; m_prev_start = 0; m_prev_select = 0;
  endtask

  task automatic modelStep(input bit en, input bit st, input bit sel, input bit fin);
    bit start_evt, select_evt;
    int reload;
    reload = TIMEOUT_EN ? TC - 1 : 0;
    m_commit = 0;
    m_timeout = 0;
    if (en) begin
      start_evt = st && !m_prev_start;
      select_evt = sel && !m_prev_select;
      m_prev_start = st;
      m_prev_select = sel;
      if (m_phase == 0 && start_evt) begin
        m_phase = 1; m_player = 0; m_timer = reload;
      end else if (m_phase == 1) begin
        if (select_evt) begin
          m_phase = 2; m_commit = 1;
        end else if (TIMEOUT_EN) begin
          if (m_timer == 0) begin
            m_timeout = 1; m_player = (m_player + 1) % N; m_timer = reload;
          end else begin
            m_timer = m_timer - 1;
          end
        end
      end else if (m_phase == 2) begin
        if (fin) begin
          m_phase = 3; m_winner = m_player;
        end else begin
          m_phase = 1; m_player = (m_player + 1) % N; m_timer = reload;
        end
      end else if (m_phase == 3 && start_evt) begin
        m_phase = 0; m_winner = 0;
      end
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input int e_state, input int e_player,
                             input int e_timer, input int e_commit, input int e_timeout,
                             input int e_go, input int e_winner);
    vectors++;
    if (int'(state) != e_state || int'(player) != e_player || int'(turn_timer) != e_timer ||
        int'(commit) != e_commit || int'(timeout) != e_timeout ||
        int'(game_over) != e_go || int'(winner) != e_winner) begin
      miscompares++;
      $display("[TB] FAIL %s: got st=%0d pl=%0d tm=%0d cm=%0d to=%0d go=%0d wn=%0d expected st=%0d pl=%0d tm=%0d cm=%0d to=%0d go=%0d wn=%0d at %0t",
               tag, state, player, turn_timer, commit, timeout, game_over, winner,
               e_state, e_player, e_timer, e_commit, e_timeout, e_go, e_winner, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, m_phase, m_player, m_timer, int'(m_commit), int'(m_timeout),
                int'(m_phase == 3), m_winner);
  endtask

  // Drive away from the active edge, let the edge happen, advance the model.
  task automatic applyStimulus(input bit en, input bit st, input bit sel, input bit fin);
    @(negedge clk);
    enable = en; start = st; select = sel; finish = fin;
    @(posedge clk);
    modelStep(en, st, sel, fin);
    #1;
  endtask

  task automatic stepChecked(input string tag, input bit en, input bit st,
                             input bit sel, input bit fin);
    applyStimulus(en, st, sel, fin);
    checkModel(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; start = 1'b0; select = 1'b0; finish = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit en, st, sel, fin;
    int e_state, e_player, e_timer, e_commit, e_timeout, e_go, e_winner;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int commits, timeouts;

    // Timer column holds the timer-enabled value; it reads 0 otherwise.
    tbl[0]  = '{1,1,0,0, 1,0,3,0,0,0,0};
    tbl[1]  = '{1,1,1,0, 2,0,3,1,0,0,0};
    tbl[2]  = '{1,0,1,0, 1,1,3,0,0,0,0};
    tbl[3]  = '{1,0,0,0, 1,1,2,0,0,0,0};
    tbl[4]  = '{1,0,1,0, 2,1,2,1,0,0,0};
    tbl[5]  = '{1,0,1,0, 1,2,3,0,0,0,0};
    tbl[6]  = '{1,0,0,0, 1,2,2,0,0,0,0};
    tbl[7]  = '{1,0,1,0, 2,2,2,1,0,0,0};
    tbl[8]  = '{1,0,0,1, 3,2,2,0,0,1,2};
    tbl[9]  = '{1,0,0,0, 3,2,2,0,0,1,2};
    tbl[10] = '{1,1,0,0, 0,2,2,0,0,0,0};
    tbl[11] = '{1,0,0,0, 0,2,2,0,0,0,0};
    tbl[12] = '{1,1,0,0, 1,0,3,0,0,0,0};
    tbl[13] = '{0,0,1,0, 1,0,3,0,0,0,0};
    tbl[14] = '{1,0,1,0, 2,0,3,1,0,0,0};

    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].en, tbl[i].st, tbl[i].sel, tbl[i].fin);
      checkOutput($sformatf("table_%0d", i), tbl[i].e_state, tbl[i].e_player,
                  TIMEOUT_EN ? tbl[i].e_timer : 0, tbl[i].e_commit, tbl[i].e_timeout,
                  tbl[i].e_go, tbl[i].e_winner);
    end

    // Turn expiry with no select.
    doReset();
    stepChecked("to_start", 1, 1, 0, 0);
    checkVal("to_start_timer", int'(turn_timer), TIMEOUT_EN ? 3 : 0);
    if (TIMEOUT_EN) begin
      for (int k = 2; k >= 0; k--) begin
        stepChecked("to_count", 1, 0, 0, 0);
        checkVal("to_count_timer", int'(turn_timer), k);
      end
      stepChecked("to_expire", 1, 0, 0, 0);
      checkVal("to_pulse", int'(timeout), 1);
      checkVal("to_player", int'(player), 1);
      checkVal("to_reload", int'(turn_timer), 3);
      stepChecked("to_after", 1, 0, 0, 0);
      checkVal("to_one_cycle", int'(timeout), 0);
      // Select rise on the expiry cycle: select wins.
      stepChecked("col_pre", 1, 0, 0, 0);
      stepChecked("col_pre", 1, 0, 0, 0);
      checkVal("col_timer_zero", int'(turn_timer), 0);
      stepChecked("col_hit", 1, 0, 1, 0);
      checkVal("col_commit", int'(commit), 1);
      checkVal("col_timeout", int'(timeout), 0);
      checkVal("col_state", int'(state), 2);
      checkVal("col_player", int'(player), 1);
    end else begin
      timeouts = 0;
      for (int k = 0; k < 20; k++) begin
        stepChecked("no_to_wait", 1, 0, 0, 0);
        if (timeout) timeouts++;
      end
      checkVal("no_to_count", timeouts, 0);
      checkVal("no_to_state", int'(state), 1);
      stepChecked("no_to_select", 1, 0, 1, 0);
    end
    stepChecked("col_release", 1, 0, 1, 0);

    // Enable low for five cycles mid-turn.
    stepChecked("en_pre", 1, 0, 0, 0);
    checkVal("en_pre_timer", int'(turn_timer), TIMEOUT_EN ? 2 : 0);
    for (int k = 0; k < 5; k++) begin
      stepChecked("en_hold", 0, k[0], ~k[0], 1);
      checkVal("en_hold_timer", int'(turn_timer), TIMEOUT_EN ? 2 : 0);
      checkVal("en_hold_commit", int'(commit), 0);
    end

    // Select held high for ten cycles gives one commit.
    commits = 0;
    for (int k = 0; k < 10; k++) begin
      stepChecked("held_select", 1, 0, 1, 0);
      if (commit) commits++;
    end
    checkVal("held_commits", commits, 1);

    // Random play against the model.
    for (int k = 0; k < 600; k++) begin
      stepChecked("random", ($urandom % 8) != 0, ($urandom % 5) == 0,
                  ($urandom % 3) == 0, ($urandom % 3) == 0);
    end

    // Asynchronous reset in the middle of a turn.
    doReset();
    stepChecked("mid_start", 1, 1, 0, 0);
    stepChecked("mid_turn", 1, 1, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset", 0, 0, 0, 0, 0, 0, 0);
    // Start held through reset release starts on the first enabled edge.
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    stepChecked("start_held", 1, 1, 0, 0);
    checkVal("start_held_state", int'(state), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
